// File: rtl/ladybird_config.sv
// Shared configuration for the ladybird core: machine width, instruction width
// and the fetch state encoding that trace/debug logic also decodes.
package ladybird_config;

    localparam int XLEN    = 32;
    localparam int INST_W  = 32;
    localparam int INST_SH = $clog2(INST_W);

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        RUN  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/ladybird_fetch.sv
// Instruction fetch stage: owns the PC, requests whole lines from the I-cache
// and serves 32-bit words to decode out of a single-entry line buffer.
module ladybird_fetch
    import ladybird_config::*;
#(
    parameter int              LINE_W   = 7,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     i_redirect,
    input  logic [XLEN-1:0]          i_redirect_pc,
    input  logic                     i_fence,
    output logic                     c_valid,
    output logic [XLEN-1:0]          c_addr,
    input  logic                     c_ready,
    input  logic                     c_rvalid,
    input  logic [XLEN-1:0]          c_raddr,
    input  logic [(1<<LINE_W)-1:0]   c_rdata,
    output logic                     c_rready,
    output logic                     inst_valid,
    output logic [XLEN-1:0]          inst_pc,
    output logic [INST_W-1:0]        inst_data,
    input  logic                     inst_ready
);

    localparam int OFF_W  = LINE_W - 3;
    localparam int TAG_W  = XLEN - OFF_W;
    localparam int DATA_W = 1 << LINE_W;

    fetch_state_t        state_q, state_d;
    logic [XLEN-1:0]     pc_q, pc_d;
    logic                buf_valid_q, buf_valid_d;
    logic [TAG_W-1:0]    buf_tag_q, buf_tag_d;
    logic [DATA_W-1:0]   buf_data_q, buf_data_d;
    logic                fence_pend_q, fence_pend_d;

    logic [XLEN-1:0]     redir_pc;
    logic [XLEN-1:0]     pc_inc;
    logic [TAG_W-1:0]    pc_tag;
    logic [TAG_W-1:0]    redir_tag;
    logic [TAG_W-1:0]    resp_tag;
    logic [TAG_W-1:0]    want_tag;
    logic [LINE_W-1:0]   word_sel;
    logic                hit;
    logic                fire;
    logic                req_fire;
    logic                unused_bits;

    assign redir_pc  = {i_redirect_pc[XLEN-1:2], 2'b00};
    assign pc_inc    = pc_q + XLEN'(4);
    assign pc_tag    = pc_q[XLEN-1:OFF_W];
    assign redir_tag = redir_pc[XLEN-1:OFF_W];
    assign resp_tag  = c_raddr[XLEN-1:OFF_W];
    // A response is matched against the line the PC will hold after this cycle.
    assign want_tag  = i_redirect ? redir_tag : pc_tag;
    assign hit       = buf_valid_q && (buf_tag_q == pc_tag);
    assign word_sel  = {pc_q[LINE_W-4:2], {INST_SH{1'b0}}};

    assign c_valid    = (state_q == REQ);
    assign c_addr     = {pc_tag, {OFF_W{1'b0}}};
    assign c_rready   = 1'b1;
    assign inst_valid = (state_q == RUN) && hit;
    assign inst_pc    = pc_q;
    assign inst_data  = buf_data_q[word_sel +: INST_W];

    assign fire     = inst_valid && inst_ready;
    assign req_fire = c_valid && c_ready;

    assign unused_bits = &{1'b0, c_raddr[OFF_W-1:0], i_redirect_pc[1:0]};

    always_comb begin
        // NOTE: every _d starts as its _q so no path through this block infers a latch.
        state_d      = state_q;
        pc_d         = pc_q;
        buf_valid_d  = buf_valid_q;
        buf_tag_d    = buf_tag_q;
        buf_data_d   = buf_data_q;
        fence_pend_d = fence_pend_q;

        if (fire)       pc_d = pc_inc;
        if (i_redirect) pc_d = redir_pc;

        unique case (state_q)
            // An accepted request always moves to WAIT, even under redirect, so
            // only one request is ever outstanding; the line compare drops it.
            REQ: if (req_fire) state_d = WAIT;
            WAIT: begin
                if (c_rvalid) begin
                    fence_pend_d = 1'b0;
                    if (!i_fence && !fence_pend_q && resp_tag == want_tag) begin
                        buf_valid_d = 1'b1;
                        buf_tag_d   = resp_tag;
                        buf_data_d  = c_rdata;
                        state_d     = RUN;
                    end else begin
                        state_d = REQ;
                    end
                end else if (i_fence) begin
                    fence_pend_d = 1'b1;
                end
            end
            RUN: begin
                if (i_redirect)
                    state_d = (buf_valid_q && redir_tag == buf_tag_q) ? RUN : REQ;
                else if (!hit || (fire && pc_inc[XLEN-1:OFF_W] != pc_tag))
                    state_d = REQ;
            end
            default: state_d = REQ;
        endcase

        if (i_fence) begin
            buf_valid_d = 1'b0;
            if (state_q == RUN) state_d = REQ;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q      <= REQ;
            pc_q         <= {RESET_PC[XLEN-1:2], 2'b00};
            buf_valid_q  <= 1'b0;
            buf_tag_q    <= '0;
            // NOTE: the line buffer is a plain register, reset so inst_data reads 0 out of reset.
            buf_data_q   <= '0;
            fence_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            buf_valid_q  <= buf_valid_d;
            buf_tag_q    <= buf_tag_d;
            buf_data_q   <= buf_data_d;
            fence_pend_q <= fence_pend_d;
        end
    end

endmodule

// File: tb/tb_ladybird_fetch.sv
// Directed bench for ladybird_fetch: a hand-driven cache model feeds known
// lines and every observed output is compared against hand-computed values.
module tb_ladybird_fetch;

    logic          clk = 1'b0;
    logic          nrst;
    logic          i_redirect;
    logic [31:0]   i_redirect_pc;
    logic          i_fence;
    logic          c_valid;
    logic [31:0]   c_addr;
    logic          c_ready;
    logic          c_rvalid;
    logic [31:0]   c_raddr;
    logic [127:0]  c_rdata;
    logic          c_rready;
    logic          inst_valid;
    logic [31:0]   inst_pc;
    logic [31:0]   inst_data;
    logic          inst_ready;

    int n_checks = 0;
    int n_fail   = 0;

    ladybird_fetch #(.LINE_W(7), .RESET_PC(32'h0)) dut (
        .clk(clk), .nrst(nrst),
        .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc), .i_fence(i_fence),
        .c_valid(c_valid), .c_addr(c_addr), .c_ready(c_ready),
        .c_rvalid(c_rvalid), .c_raddr(c_raddr), .c_rdata(c_rdata), .c_rready(c_rready),
        .inst_valid(inst_valid), .inst_pc(inst_pc), .inst_data(inst_data),
        .inst_ready(inst_ready)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a request, accept it, answer with a line one cycle later.
    task automatic serve(input logic [31:0] exp_addr, input logic [127:0] line);
        int waited = 0;
        while (c_valid !== 1'b1 && waited < 8) begin
            tick();
            waited++;
        end
        n_checks++;
        if (c_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL serve_req_timeout: c_valid=%b expected 1", c_valid);
        end
        n_checks++;
        if (c_addr !== exp_addr) begin
            n_fail++;
            $display("FAIL serve_addr: c_addr=%h expected %h", c_addr, exp_addr);
        end
        c_ready = 1'b1;
        tick();
        c_ready  = 1'b0;
        c_rvalid = 1'b1;
        c_raddr  = exp_addr;
        c_rdata  = line;
        tick();
        c_rvalid = 1'b0;
        c_rdata  = '0;
        n_checks++;
        if (inst_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL serve_inst_valid: inst_valid=%b expected 1", inst_valid);
        end
    endtask

    task automatic redirect_to(input logic [31:0] target);
        i_redirect    = 1'b1;
        i_redirect_pc = target;
        tick();
        i_redirect    = 1'b0;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        i_redirect = 1'b0; i_redirect_pc = '0; i_fence = 1'b0;
        c_ready = 1'b0; c_rvalid = 1'b0; c_raddr = '0; c_rdata = '0;
        inst_ready = 1'b0;
        tick();
        tick();
        nrst = 1'b1;
        n_checks++;
        if (c_valid !== 1'b1) begin n_fail++; $display("FAIL reset_c_valid: got %b expected 1", c_valid); end
        n_checks++;
        if (c_addr !== 32'h0) begin n_fail++; $display("FAIL reset_c_addr: got %h expected 0", c_addr); end
        n_checks++;
        if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_inst_valid: got %b expected 0", inst_valid); end
        n_checks++;
        if (inst_pc !== 32'h0) begin n_fail++; $display("FAIL reset_inst_pc: got %h expected 0", inst_pc); end
        n_checks++;
        if (inst_data !== 32'h0) begin n_fail++; $display("FAIL reset_inst_data: got %h expected 0", inst_data); end
        n_checks++;
        if (c_rready !== 1'b1) begin n_fail++; $display("FAIL reset_c_rready: got %b expected 1", c_rready); end
    endtask

    task automatic test_sequential();
        logic [31:0] words [4] = '{32'h13, 32'h93, 32'h113, 32'h193};
        serve(32'h0, {32'h193, 32'h113, 32'h93, 32'h13});
        inst_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (inst_valid !== 1'b1 || inst_pc !== 32'(4 * i) || inst_data !== words[i]) begin
                n_fail++;
                $display("FAIL seq_word%0d: valid=%b pc=%h data=%h expected 1 %h %h",
                         i, inst_valid, inst_pc, inst_data, 32'(4 * i), words[i]);
            end
            tick();
        end
        inst_ready = 1'b0;
        n_checks++;
        if (c_valid !== 1'b1 || c_addr !== 32'h10 || inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL seq_line_cross: c_valid=%b c_addr=%h inst_valid=%b expected 1 00000010 0",
                     c_valid, c_addr, inst_valid);
        end
    endtask

    task automatic test_backpressure();
        redirect_to(32'h4);
        n_checks++;
        if (c_valid !== 1'b1 || c_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL bp_redirect_in_req: c_valid=%b c_addr=%h expected 1 0", c_valid, c_addr);
        end
        serve(32'h0, {32'h193, 32'h113, 32'h93, 32'h13});
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (inst_valid !== 1'b1 || inst_pc !== 32'h4 || inst_data !== 32'h93 || c_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold%0d: valid=%b pc=%h data=%h c_valid=%b expected 1 4 93 0",
                         i, inst_valid, inst_pc, inst_data, c_valid);
            end
            tick();
        end
    endtask

    task automatic test_redirect_in_line();
        redirect_to(32'h0);
        n_checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_data !== 32'h13) begin
            n_fail++;
            $display("FAIL redir_to0: valid=%b pc=%h data=%h expected 1 0 13", inst_valid, inst_pc, inst_data);
        end
        redirect_to(32'h0A);
        n_checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h8 || inst_data !== 32'h113 || c_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_in_line: valid=%b pc=%h data=%h c_valid=%b expected 1 8 113 0",
                     inst_valid, inst_pc, inst_data, c_valid);
        end
    endtask

    task automatic test_stale_response();
        redirect_to(32'h100);
        n_checks++;
        if (c_valid !== 1'b1 || c_addr !== 32'h100 || inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stale_req: c_valid=%b c_addr=%h inst_valid=%b expected 1 100 0", c_valid, c_addr, inst_valid);
        end
        c_ready = 1'b1;
        tick();
        c_ready = 1'b0;
        redirect_to(32'h200);
        n_checks++;
        if (c_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stale_wait_hold: c_valid=%b expected 0", c_valid);
        end
        c_rvalid = 1'b1;
        c_raddr  = 32'h100;
        c_rdata  = {4{32'hBAD0_0100}};
        tick();
        c_rvalid = 1'b0;
        c_rdata  = '0;
        n_checks++;
        if (inst_valid !== 1'b0 || c_valid !== 1'b1 || c_addr !== 32'h200) begin
            n_fail++;
            $display("FAIL stale_discard: inst_valid=%b c_valid=%b c_addr=%h expected 0 1 200",
                     inst_valid, c_valid, c_addr);
        end
        serve(32'h200, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
        n_checks++;
        if (inst_pc !== 32'h200 || inst_data !== 32'hA0) begin
            n_fail++;
            $display("FAIL stale_new_line: pc=%h data=%h expected 200 a0", inst_pc, inst_data);
        end
    endtask

    task automatic test_fence();
        i_fence = 1'b1;
        tick();
        i_fence = 1'b0;
        n_checks++;
        if (inst_valid !== 1'b0 || c_valid !== 1'b1 || c_addr !== 32'h200) begin
            n_fail++;
            $display("FAIL fence_run: inst_valid=%b c_valid=%b c_addr=%h expected 0 1 200",
                     inst_valid, c_valid, c_addr);
        end
        c_ready = 1'b1;
        tick();
        c_ready  = 1'b0;
        i_fence  = 1'b1;
        c_rvalid = 1'b1;
        c_raddr  = 32'h200;
        c_rdata  = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        tick();
        i_fence  = 1'b0;
        c_rvalid = 1'b0;
        c_rdata  = '0;
        n_checks++;
        if (inst_valid !== 1'b0 || c_valid !== 1'b1 || c_addr !== 32'h200) begin
            n_fail++;
            $display("FAIL fence_wait_drop: inst_valid=%b c_valid=%b c_addr=%h expected 0 1 200",
                     inst_valid, c_valid, c_addr);
        end
        serve(32'h200, {32'hB3, 32'hB2, 32'hB1, 32'hB0});
        n_checks++;
        if (inst_pc !== 32'h200 || inst_data !== 32'hB0) begin
            n_fail++;
            $display("FAIL fence_refetch: pc=%h data=%h expected 200 b0", inst_pc, inst_data);
        end
    endtask

    task automatic test_wrap_and_miss();
        int early = 0;
        redirect_to(32'hFFFF_FFFC);
        serve(32'hFFFF_FFF0, {32'hDEAD_0003, 32'hDEAD_0002, 32'hDEAD_0001, 32'hDEAD_0000});
        n_checks++;
        if (inst_pc !== 32'hFFFF_FFFC || inst_data !== 32'hDEAD_0003) begin
            n_fail++;
            $display("FAIL wrap_last_word: pc=%h data=%h expected fffffffc dead0003", inst_pc, inst_data);
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        n_checks++;
        if (c_valid !== 1'b1 || c_addr !== 32'h0 || inst_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_req: c_valid=%b c_addr=%h pc=%h expected 1 0 0", c_valid, c_addr, inst_pc);
        end
        c_ready = 1'b1;
        tick();
        c_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (inst_valid !== 1'b0 || c_valid !== 1'b0) early++;
            tick();
        end
        n_checks++;
        if (early !== 0) begin
            n_fail++;
            $display("FAIL miss_wait: %0d cycles with activity expected 0", early);
        end
        c_rvalid = 1'b1;
        c_raddr  = 32'h0;
        c_rdata  = {32'h193, 32'h113, 32'h93, 32'h13};
        tick();
        c_rvalid = 1'b0;
        c_rdata  = '0;
        n_checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_data !== 32'h13) begin
            n_fail++;
            $display("FAIL miss_resp: valid=%b pc=%h data=%h expected 1 0 13", inst_valid, inst_pc, inst_data);
        end
    endtask

    task automatic test_reset_midop();
        nrst = 1'b0;
        tick();
        nrst     = 1'b1;
        c_rvalid = 1'b1;
        c_raddr  = 32'h0;
        c_rdata  = {4{32'h5555_AAAA}};
        tick();
        c_rvalid = 1'b0;
        c_rdata  = '0;
        n_checks++;
        if (inst_valid !== 1'b0 || c_valid !== 1'b1 || c_addr !== 32'h0 || inst_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_late_resp: valid=%b c_valid=%b c_addr=%h data=%h expected 0 1 0 0",
                     inst_valid, c_valid, c_addr, inst_data);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_in_line();
        test_stale_response();
        test_fence();
        test_wrap_and_miss();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ladybird_fetch.md
# ladybird_fetch

Instruction fetch stage that sits directly upstream of the instruction-side `ladybird_cache`. It holds the program counter and issues line-aligned read requests to the cache, and it captures the returned cache line in a single-entry line buffer. From that buffer it serves 32-bit instructions to decode, one per handshake, and it refetches on a line crossing, a redirect or a fence.

## Interface
Parameters:
- `LINE_W`, default 7: log2 of line size in bits; must equal the cache's `LINE_W`.
- `RESET_PC`, default `32'h0000_0000`: PC loaded at reset.

Ports:
- `clk`  in  1  clock.
- `nrst`  in  1  reset, synchronous, active-low.
- `i_redirect`  in  1  redirect PC (branch, jump or trap).
- `i_redirect_pc`  in  XLEN  redirect target.
- `i_fence`  in  1  invalidate the line buffer (fence.i).
- `c_valid`  out  1  cache request valid.
- `c_addr`  out  XLEN  request address, line aligned.
- `c_ready`  in  1  cache accepts the request.
- `c_rvalid`  in  1  cache response valid.
- `c_raddr`  in  XLEN  response address.
- `c_rdata`  in  2**LINE_W  response line.
- `c_rready`  out  1  response enable; constant 1.
- `inst_valid`  out  1  instruction valid.
- `inst_pc`  out  XLEN  PC of `inst_data`.
- `inst_data`  out  32  instruction word.
- `inst_ready`  in  1  decode accepts the instruction.

The parent ties the cache's `i_wen`, `i_data`, `i_uncache`, `i_flush` and `i_invalidate` to 0.

## Operation
- Registers:
  - `pc`, with bits [1:0] always 0.
  - Buffer: `buf_valid`, `buf_tag` (= `addr[XLEN-1:LINE_W-3]`) and `buf_data`.
  - `state` ∈ {REQ, WAIT, RUN}.
- Definitions:
  - `hit = buf_valid && buf_tag == pc[XLEN-1:LINE_W-3]`.
  - Word index = `pc[LINE_W-4:2]`.
  - `inst_data` = `buf_data[index*32 +: 32]`.
- REQ:
  - `c_valid=1`, `c_addr = {pc[XLEN-1:LINE_W-3], '0}`.
  - On `c_valid && c_ready` → WAIT.
  - `c_addr` is held stable while `c_ready=0`.
- WAIT:
  - `c_rvalid` with the `c_raddr` line equal to the `pc` line: load the buffer and set `buf_valid` → RUN.
  - `c_rvalid` with a mismatching line (stale, from a pre-redirect request): discard → REQ.
  - No `c_rvalid`: stay in WAIT.
- RUN:
  - `inst_valid = hit`, `inst_pc = pc`.
  - On `inst_valid && inst_ready`: `pc <= pc + 4`, modulo 2^XLEN (`FFFF_FFFC` wraps to 0).
  - If the next `pc` leaves the line → REQ.
- Redirect (any state):
  - `pc <= {i_redirect_pc[XLEN-1:2], 2'b0}`.
  - From RUN: if the target line equals `buf_tag` and the buffer is valid, stay in RUN; else → REQ.
  - From REQ: stay in REQ; `c_addr` changes only if `c_ready=0` in that cycle.
  - From WAIT: stay in WAIT; the stale response is then discarded by the line compare.
- Simultaneous events:
  - Handshake together with redirect: the instruction is consumed and the redirect wins the `pc` update.
- Fence:
  - `buf_valid <= 0`.
  - If not in WAIT → REQ. In WAIT, a response arriving in the same cycle is still dropped (fence has priority over the buffer load); the state then → REQ.
  - Fence together with redirect: both apply.
- `c_rvalid` outside WAIT is ignored.
- At most one request is outstanding.

## Timing
- Reset values:
  - `state=REQ`, `pc=RESET_PC`, `buf_valid=0`.
  - `c_valid=1` in the first cycle after reset release; `c_addr` = line of `RESET_PC`.
  - `inst_valid=0`, `inst_pc=RESET_PC`, `inst_data=0`, `c_rready=1`.
- Reset mid-operation returns to these values. A late cache response arrives in REQ and is ignored.
- Outputs depend only on registers, so there is no combinational input→output path (except `c_rready` constant).
- Line-crossing fetch, cache hit:
  - Last-word handshake at t; REQ at t+1 with the request accepted at t+1.
  - WAIT at t+2 with `c_rvalid` at t+2 (the cache output is registered).
  - `inst_valid` at t+3.
- Cache miss: WAIT lasts until the cache's REFRESH response; the latency is unbounded.
- Within a line: one instruction per cycle while `inst_ready=1`.
- Redirect into the buffered line: `inst_valid` at the next cycle with the new PC.

## Structure
- `XLEN` comes from `ladybird_config`.
- Add to `ladybird_config`:
  - `INST_W = 32`.
  - `fetch_state_t` enum {REQ, WAIT, RUN}, 2 bits, for sharing with trace/debug.
- No sub-module. The word select is an indexed part-select inside the module. Expected size 150–250 lines.

## Test plan
- **Reset/sequential fetch:** `RESET_PC=0`; cache returns line 0 = {`0x13`, `0x93`, `0x113`, `0x193`} at word 0..3 → `inst_pc` 0, 4, 8, C with those words on consecutive cycles; then `c_valid` with `c_addr=0x10`.
- **Backpressure:** hold `inst_ready=0` for 5 cycles at pc=4 → `inst_valid`, `inst_pc` and `inst_data` stable; no request issued.
- **Redirect in line:** at pc=0, redirect to `0x0A` → next cycle `inst_pc=0x08` with no cache request.
- **Stale response:** request line `0x100` in WAIT, redirect to `0x200`, cache returns `c_raddr=0x100` → discarded; REQ `c_addr=0x200`; no instruction from `0x100` is emitted.
- **Fence during RUN, and fence in WAIT concurrent with `c_rvalid`:** RUN case → `inst_valid` drops and the same line is re-requested. WAIT case → the response is dropped, `buf_valid=0`, and the line is re-requested.
- **Wrap and miss latency:** redirect to `FFFF_FFFC`, then a handshake → `c_addr=0`. Cache with 20-cycle miss → `inst_valid` appears exactly one cycle after `c_rvalid`.
